// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the serial transmit/receive pair.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Codeword is returned in position order: bit 6 = position 1 (p1) ... bit 0 = position 7 (d4).
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic p1, p2, p4;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p4 = d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[3], p4, d[2], d[1], d[0]};
  endfunction

endpackage

// File: rtl/hamming_serial_tx_if.sv
// Nibble handshake plus serial line outputs of the Hamming transmitter.
interface hamming_serial_tx_if;
  import hamming_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              data_line;
  logic              strobe;
  logic              frame_done;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, data_line, strobe, frame_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, data_line, strobe, frame_done, busy
  );

endinterface

// File: rtl/nibble_fifo.sv
// Small show-ahead synchronous FIFO for 4-bit nibbles.
module nibble_fifo
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_en,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   rd_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // A write is refused while full, even if a read frees a slot on the same edge.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally for power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) serial transmitter: FIFO-buffered nibbles sent as strobed 7-bit frames.
//
// state | meaning
// IDLE  | line quiet, waiting for a queued nibble
// SHIFT | frame bits on the line, cnt = index of bit currently driven
// GAP   | strobe held low between frames, gcnt counts low cycles
module hamming_serial_tx
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  hamming_serial_tx_if.slave bus
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t              state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic [GW-1:0]       gcnt, gcnt_n;
  logic [CODE_W-2:0]   sreg, sreg_n;
  logic                data_q, data_n;
  logic                strobe_q, strobe_n;
  logic                done_q, done_n;
  logic                pop;
  logic [CODE_W-1:0]   codeword;

  logic [DATA_W-1:0]     fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (bus.in_data),
    .wr_en   (bus.in_valid),
    .rd_data (fifo_rd_data),
    .rd_en   (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign codeword       = hamming_encode(fifo_rd_data);
  assign bus.in_ready   = !fifo_full;
  assign bus.data_line  = data_q;
  assign bus.strobe     = strobe_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = (state != IDLE) || (fifo_count != '0);

  // Next-state and next-output logic; the shift register holds only the bits not yet driven.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    sreg_n   = sreg;
    data_n   = 1'b0;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          sreg_n   = codeword[CODE_W-2:0];
          data_n   = codeword[CODE_W-1];
          strobe_n = 1'b1;
          cnt_n    = 3'd0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != 3'd6) begin
          data_n   = sreg[CODE_W-2];
          sreg_n   = {sreg[CODE_W-3:0], 1'b0};
          strobe_n = 1'b1;
          cnt_n    = cnt + 3'd1;
        end else begin
          done_n  = 1'b1;
          gcnt_n  = '0;
          state_n = hamming_pkg::GAP;
        end
      end
      hamming_pkg::GAP: begin
        gcnt_n = gcnt + 1'b1;
        if (gcnt == GW'(GAP - 1)) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            sreg_n   = codeword[CODE_W-2:0];
            data_n   = codeword[CODE_W-1];
            strobe_n = 1'b1;
            cnt_n    = 3'd0;
            state_n  = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered line outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      sreg     <= '0;
      data_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      gcnt     <= gcnt_n;
      sreg     <= sreg_n;
      data_q   <= data_n;
      strobe_q <= strobe_n;
      done_q   <= done_n;
    end
  end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Self-checking bench: one transmitter with GAP=1, one with GAP=3.
module tb_hamming_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   idle_viol = 0;

  always #5 clk = ~clk;

  logic [3:0] tb_data = 4'h0;
  logic       tb_valid = 1'b0;
  int         sel = 0;

  hamming_serial_tx_if b0();
  hamming_serial_tx_if b1();

  hamming_serial_tx #(.DEPTH(4), .GAP(1)) u_g1 (.clk(clk), .rst(rst), .bus(b0.slave));
  hamming_serial_tx #(.DEPTH(4), .GAP(3)) u_g3 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b0.in_data  = tb_data;
  assign b1.in_data  = tb_data;
  assign b0.in_valid = tb_valid && (sel == 0);
  assign b1.in_valid = tb_valid && (sel == 1);

  logic st[2], dl[2], fd[2], rdy[2], bsy[2], vld[2];
  assign st[0] = b0.strobe;     assign st[1] = b1.strobe;
  assign dl[0] = b0.data_line;  assign dl[1] = b1.data_line;
  assign fd[0] = b0.frame_done; assign fd[1] = b1.frame_done;
  assign rdy[0] = b0.in_ready;  assign rdy[1] = b1.in_ready;
  assign bsy[0] = b0.busy;      assign bsy[1] = b1.busy;
  assign vld[0] = b0.in_valid;  assign vld[1] = b1.in_valid;

  // Reference encoder built from the parity-check definition (parity p covers positions with bit p set).
  function automatic logic [6:0] tb_encode(input logic [3:0] d);
    logic pos [1:7];
    logic [6:0] cw;
    for (int j = 1; j <= 7; j++) pos[j] = 1'b0;
    pos[3] = d[3]; pos[5] = d[2]; pos[6] = d[1]; pos[7] = d[0];
    for (int p = 1; p <= 4; p = p * 2)
      for (int j = 3; j <= 7; j++)
        if (j != 4 && (j & p) != 0) pos[p] = pos[p] ^ pos[j];
    for (int j = 1; j <= 7; j++) cw[7-j] = pos[j];
    return cw;
  endfunction

  // Syndrome decoder standing in for the downstream error-correct block.
  function automatic logic [3:0] tb_decode(input logic [6:0] cw);
    logic pos [1:7];
    int s;
    s = 0;
    for (int j = 1; j <= 7; j++) begin
      pos[j] = cw[7-j];
      if (pos[j]) s = s ^ j;
    end
    if (s != 0) pos[s] = ~pos[s];
    return {pos[3], pos[5], pos[6], pos[7]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard state per DUT: queued {nibble, codeword}, frame assembly, frame start cycles.
  logic [10:0] expq [2][$];
  int          starts [2][$];
  logic [6:0]  frm [2];
  int          nb [2];
  logic        dexp [2];
  int          frames [2];
  int          shi [2];
  logic [10:0] mon_e;
  logic [6:0]  mon_m;

  initial begin
    for (int d = 0; d < 2; d++) begin
      frm[d] = '0; nb[d] = 0; dexp[d] = 1'b0; frames[d] = 0; shi[d] = 0;
    end
  end

  // Record each accepted nibble with its expected codeword.
  always @(posedge clk) begin
    cyc++;
    if (!rst)
      for (int d = 0; d < 2; d++)
        if (vld[d] && rdy[d]) expq[d].push_back({tb_data, tb_encode(tb_data)});
  end

  // Assemble strobed bits into frames and compare against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        expq[d].delete();
        nb[d] = 0;
        dexp[d] = 1'b0;
      end else begin
        if (fd[d] || dexp[d]) check($sformatf("frame_done_dut%0d", d), 32'(fd[d]), 32'(dexp[d]));
        dexp[d] = 1'b0;
        if (!st[d] && dl[d]) idle_viol++;
        if (st[d]) begin
          shi[d]++;
          if (nb[d] == 0) starts[d].push_back(cyc);
          frm[d] = {frm[d][5:0], dl[d]};
          nb[d]++;
          if (nb[d] == 7) begin
            nb[d] = 0;
            frames[d]++;
            dexp[d] = 1'b1;
            if (expq[d].size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_frame dut%0d: got %b, expected no frame", d, frm[d]);
            end else begin
              mon_e = expq[d].pop_front();
              check($sformatf("frame_code_dut%0d", d), 32'(frm[d]), 32'(mon_e[6:0]));
              if (d == 1) begin
                check("decode_clean", 32'(tb_decode(frm[d])), 32'(mon_e[10:7]));
                for (int p = 1; p <= 7; p++) begin
                  mon_m = 7'b1000000 >> (p - 1);
                  check($sformatf("decode_inject_pos%0d", p), 32'(tb_decode(frm[d] ^ mon_m)), 32'(mon_e[10:7]));
                end
              end
            end
          end
        end else if (nb[d] != 0) begin
          tests++; fails++;
          $display("FAIL frame_cut dut%0d: got %0d bits, expected 7", d, nb[d]);
          nb[d] = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input int s, input logic [3:0] d);
    int  guard;
    logic r;
    guard = 0;
    sel = s; tb_data = d; tb_valid = 1'b1;
    do begin
      @(negedge clk);
      r = rdy[s];
      if (!r) stalls++;
      @(posedge clk); #1;
      guard++;
    end while (!r && guard < 200);
    if (!r) check("push_timeout", 32'(r), 32'd1);
    tb_valid = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int g;
    g = 0;
    while ((bsy[s] || st[s]) && g < 200) begin
      @(posedge clk); #2;
      g++;
    end
    check($sformatf("idle_reached_dut%0d", s), 32'(g < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [6:0] code;
  } vec_t;

  vec_t tbl [8];
  logic [6:0] bits;
  logic sthi;
  int f0, s0;
  logic [3:0] burst [6];
  logic [3:0] g3n [4];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1011, 7'b0110011};
    tbl[1] = '{4'b0000, 7'b0000000};
    tbl[2] = '{4'b1111, 7'b1111111};
    tbl[3] = '{4'b0001, 7'b1101001};
    tbl[4] = '{4'b1000, 7'b1110000};
    tbl[5] = '{4'b0100, 7'b1001100};
    tbl[6] = '{4'b0010, 7'b0101010};
    tbl[7] = '{4'b0110, 7'b1100110};
    burst = '{4'h3, 4'h5, 4'h9, 4'hA, 4'hC, 4'hE};
    g3n   = '{4'hB, 4'h0, 4'hF, 4'h1};

    #1 rst = 1'b1;
    #11;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd1);
      check($sformatf("rst_strobe%0d", d), 32'(st[d]), 32'd0);
      check($sformatf("rst_data%0d", d), 32'(dl[d]), 32'd0);
      check($sformatf("rst_done%0d", d), 32'(fd[d]), 32'd0);
      check($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'd0);
    end
    @(posedge clk); #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single frames from an idle block: bits 1..7 after edges k+1..k+7, done after k+8.
    for (int v = 0; v < 8; v++) begin
      push(0, tbl[v].nib);
      bits = '0; sthi = 1'b1;
      for (int i = 0; i < 7; i++) begin
        @(posedge clk); #2;
        bits = {bits[5:0], dl[0]};
        sthi = sthi & st[0];
      end
      check($sformatf("tbl_code_%b", tbl[v].nib), 32'(bits), 32'(tbl[v].code));
      check("tbl_strobe_high", 32'(sthi), 32'd1);
      @(posedge clk); #2;
      check("tbl_strobe_end", 32'(st[0]), 32'd0);
      check("tbl_done_high", 32'(fd[0]), 32'd1);
      @(posedge clk); #2;
      check("tbl_done_pulse", 32'(fd[0]), 32'd0);
      wait_idle(0);
    end

    // Back-to-back frames, GAP=1: period 8 cycles.
    starts[0].delete();
    f0 = frames[0];
    push(0, 4'b0000);
    push(0, 4'b1111);
    push(0, 4'b0001);
    wait_idle(0);
    check("b2b_frames", 32'(frames[0] - f0), 32'd3);
    check("b2b_starts", 32'(starts[0].size()), 32'd3);
    if (starts[0].size() == 3) begin
      check("b2b_period_1", 32'(starts[0][1] - starts[0][0]), 32'd8);
      check("b2b_period_2", 32'(starts[0][2] - starts[0][1]), 32'd8);
    end

    // Burst of 6 into a 4-deep FIFO with valid held high.
    stalls = 0;
    f0 = frames[0];
    for (int i = 0; i < 6; i++) push(0, burst[i]);
    check("burst_stalls", 32'(stalls), 32'd5);
    wait_idle(0);
    check("burst_frames", 32'(frames[0] - f0), 32'd6);
    check("burst_queue_drained", 32'(expq[0].size()), 32'd0);

    // Reset during bit 4 of a frame with two nibbles queued.
    push(0, 4'h2);
    push(0, 4'h7);
    push(0, 4'h4);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rstmid_strobe_before", 32'(st[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_strobe", 32'(st[0]), 32'd0);
    check("rstmid_data", 32'(dl[0]), 32'd0);
    check("rstmid_done", 32'(fd[0]), 32'd0);
    check("rstmid_ready", 32'(rdy[0]), 32'd1);
    check("rstmid_busy", 32'(bsy[0]), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    s0 = shi[0]; f0 = frames[0];
    repeat (30) @(posedge clk);
    #1;
    check("rstmid_no_frame", 32'(shi[0] - s0), 32'd0);
    check("rstmid_idle_busy", 32'(bsy[0]), 32'd0);
    push(0, 4'h6);
    wait_idle(0);
    check("rstmid_new_frame", 32'(frames[0] - f0), 32'd1);
    check("rstmid_queue_drained", 32'(expq[0].size()), 32'd0);

    // GAP=3 under backlog: period 10; monitor decodes every frame with injected errors.
    starts[1].delete();
    f0 = frames[1];
    for (int i = 0; i < 4; i++) push(1, g3n[i]);
    wait_idle(1);
    check("g3_frames", 32'(frames[1] - f0), 32'd4);
    check("g3_starts", 32'(starts[1].size()), 32'd4);
    if (starts[1].size() == 4)
      for (int i = 1; i < 4; i++)
        check($sformatf("g3_period_%0d", i), 32'(starts[1][i] - starts[1][i-1]), 32'd10);

    check("data_line_low_without_strobe", 32'(idle_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
